// File: rtl/pc_branch_unit.sv
// Program-counter / status-register stage after the ALU: IDLE/RUN/HALTED sequencing,
// branch resolution through a writable target table, flag/overflow feedback and a run-cycle counter.
module pc_branch_unit #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int IDX_W     = $clog2(LUT_DEPTH),
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             HALT,
  input  logic             STALL,
  input  logic             BRANCH_EN,
  input  logic [IDX_W-1:0] TARGET_IDX,
  input  logic             FLAG_NEXT,
  input  logic             FLAG_WE,
  input  logic             OVF_NEXT,
  input  logic             OVF_WE,
  input  logic             LUT_WE,
  input  logic [IDX_W-1:0] LUT_WADDR,
  input  logic [PC_W-1:0]  LUT_WDATA,
  output logic [PC_W-1:0]  PC,
  output logic             FLAG,
  output logic             OVERFLOW,
  output logic             BRANCH_TAKEN,
  output logic             RUNNING,
  output logic             DONE,
  output logic [CNT_W-1:0] CYCLE_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic             flag_reg, flag_next;
  logic             ovf_reg, ovf_next;
  logic             taken_reg, taken_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [PC_W-1:0]      lut_reg [LUT_DEPTH];
  logic [LUT_DEPTH-1:0] lut_wsel;

  genvar gi;
  generate
    for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut_sel
      assign lut_wsel[gi] = LUT_WE && (LUT_WADDR == IDX_W'(gi));
    end
  endgenerate

  // Target table must clear on reset, so it lives in flops rather than RAM.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_reg[i] <= '0;
    end else begin
      for (int i = 0; i < LUT_DEPTH; i++)
        if (lut_wsel[i]) lut_reg[i] <= LUT_WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      flag_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      taken_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      flag_reg  <= flag_next;
      ovf_reg   <= ovf_next;
      taken_reg <= taken_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flag_next  = flag_reg;
    ovf_next   = ovf_reg;
    taken_next = 1'b0;
    cnt_next   = cnt_reg;

    if (START) begin
      // Restart from any state; overrides halt, stall and branch.
      state_next = ST_RUN;
      pc_next    = '0;
      flag_next  = 1'b0;
      ovf_next   = 1'b0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: pc_next = '0;
        ST_RUN: begin
          if (!STALL) begin
            cnt_next = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
            if (FLAG_WE) flag_next = FLAG_NEXT;
            if (OVF_WE)  ovf_next  = OVF_NEXT;
            if (HALT) begin
              state_next = ST_HALTED;
            end else if (BRANCH_EN) begin
              pc_next    = lut_reg[TARGET_IDX];
              taken_next = 1'b1;
            end else begin
              pc_next = pc_reg + PC_W'(1);
            end
          end
        end
        ST_HALTED: ;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign PC           = pc_reg;
  assign FLAG         = flag_reg;
  assign OVERFLOW     = ovf_reg;
  assign BRANCH_TAKEN = taken_reg;
  assign RUNNING      = (state_reg == ST_RUN);
  assign DONE         = (state_reg == ST_HALTED);
  assign CYCLE_CNT    = cnt_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios with literal expectations plus randomized
// traffic, all outputs compared every cycle against a behavioural model.
module tb_pc_branch_unit;

  localparam int PC_W = 10, LUT_DEPTH = 16, IDX_W = 4, CNT_W = 16;
  localparam int PC_MOD = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET_N, START, HALT, STALL, BRANCH_EN, FLAG_NEXT, FLAG_WE, OVF_NEXT, OVF_WE, LUT_WE;
  logic [IDX_W-1:0] TARGET_IDX, LUT_WADDR;
  logic [PC_W-1:0]  LUT_WDATA;
  logic [PC_W-1:0]  PC;
  logic             FLAG, OVERFLOW, BRANCH_TAKEN, RUNNING, DONE;
  logic [CNT_W-1:0] CYCLE_CNT;

  pc_branch_unit #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .HALT(HALT), .STALL(STALL),
    .BRANCH_EN(BRANCH_EN), .TARGET_IDX(TARGET_IDX), .FLAG_NEXT(FLAG_NEXT), .FLAG_WE(FLAG_WE),
    .OVF_NEXT(OVF_NEXT), .OVF_WE(OVF_WE), .LUT_WE(LUT_WE), .LUT_WADDR(LUT_WADDR),
    .LUT_WDATA(LUT_WDATA), .PC(PC), .FLAG(FLAG), .OVERFLOW(OVERFLOW),
    .BRANCH_TAKEN(BRANCH_TAKEN), .RUNNING(RUNNING), .DONE(DONE), .CYCLE_CNT(CYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Behavioural model: mode 0=idle, 1=running, 2=halted
  int m_mode, m_pc, m_flag, m_ovf, m_taken, m_cnt;
  int m_lut [LUT_DEPTH];

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_flag = 0; m_ovf = 0; m_taken = 0; m_cnt = 0;
    for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = 0;
  endtask

  task automatic model_step();
    int new_taken;
    new_taken = 0;
    if (START) begin
      m_mode = 1; m_pc = 0; m_flag = 0; m_ovf = 0; m_cnt = 0;
    end else if (m_mode == 1 && !STALL) begin
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (FLAG_WE) m_flag = FLAG_NEXT;
      if (OVF_WE)  m_ovf  = OVF_NEXT;
      if (HALT) m_mode = 2;
      else if (BRANCH_EN) begin
        m_pc = m_lut[TARGET_IDX];
        new_taken = 1;
      end else m_pc = (m_pc + 1) % PC_MOD;
    end
    m_taken = new_taken;
    if (LUT_WE) m_lut[LUT_WADDR] = int'(LUT_WDATA);
  endtask

  always @(posedge CLK) if (RESET_N) model_step();

  always @(negedge CLK) begin
    if (check_en) begin
      checks++;
      if (int'(PC) != m_pc || int'(FLAG) != m_flag || int'(OVERFLOW) != m_ovf ||
          int'(BRANCH_TAKEN) != m_taken || int'(RUNNING) != int'(m_mode == 1) ||
          int'(DONE) != int'(m_mode == 2) || int'(CYCLE_CNT) != m_cnt) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual pc=%h f=%0d o=%0d bt=%0d run=%0d done=%0d cnt=%0d required pc=%h f=%0d o=%0d bt=%0d run=%0d done=%0d cnt=%0d",
                 $time, PC, FLAG, OVERFLOW, BRANCH_TAKEN, RUNNING, DONE, CYCLE_CNT,
                 m_pc, m_flag, m_ovf, m_taken, int'(m_mode == 1), int'(m_mode == 2), m_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  task automatic clr();
    START = 0; HALT = 0; STALL = 0; BRANCH_EN = 0; TARGET_IDX = '0; FLAG_NEXT = 0; FLAG_WE = 0;
    OVF_NEXT = 0; OVF_WE = 0; LUT_WE = 0; LUT_WADDR = '0; LUT_WDATA = '0;
  endtask

  // One clock: inputs already set, returns at the following negedge
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic step_clr();
    tick(); clr();
  endtask

  task automatic do_start();
    START = 1; step_clr();
  endtask

  task automatic lut_load(input int idx, input int val);
    STALL = 1; LUT_WE = 1; LUT_WADDR = IDX_W'(idx); LUT_WDATA = PC_W'(val);
    step_clr();
  endtask

  task automatic branch(input int idx);
    BRANCH_EN = 1; TARGET_IDX = IDX_W'(idx); step_clr();
  endtask

  initial begin
    clr();
    model_reset();
    RESET_N = 0;
    repeat (3) @(negedge CLK);
    chk("reset_pc", 32'(PC), 32'h0);
    chk("reset_running", 32'(RUNNING), 32'h0);
    chk("reset_done", 32'(DONE), 32'h0);
    chk("reset_cnt", 32'(CYCLE_CNT), 32'h0);
    RESET_N = 1;
    check_en = 1;
    tick();
    chk("idle_pc", 32'(PC), 32'h0);

    do_start();
    chk("start_pc", 32'(PC), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step_clr();
      chk($sformatf("seq_pc%0d", i), 32'(PC), 32'(i));
    end
    chk("seq_cnt", 32'(CYCLE_CNT), 32'd5);
    chk("seq_running", 32'(RUNNING), 32'h1);
    chk("seq_flag", 32'(FLAG), 32'h0);
    chk("seq_ovf", 32'(OVERFLOW), 32'h0);

    // Branch through LUT[3], first under stall, then for real
    lut_load(3, 'h1A0);
    step_clr(); step_clr();
    chk("pre_branch_pc", 32'(PC), 32'h7);
    STALL = 1; branch(3);
    chk("stall_branch_pc", 32'(PC), 32'h7);
    chk("stall_branch_taken", 32'(BRANCH_TAKEN), 32'h0);
    branch(3);
    chk("branch_pc", 32'(PC), 32'h1A0);
    chk("branch_taken", 32'(BRANCH_TAKEN), 32'h1);
    step_clr();
    chk("branch_taken_drop", 32'(BRANCH_TAKEN), 32'h0);
    chk("after_branch_pc", 32'(PC), 32'h1A1);

    // Status registers
    do_start(); step_clr(); step_clr();
    chk("flag_at_pc", 32'(PC), 32'h2);
    FLAG_WE = 1; FLAG_NEXT = 1; step_clr();
    chk("flag_set", 32'(FLAG), 32'h1);
    step_clr();
    chk("flag_hold", 32'(FLAG), 32'h1);
    STALL = 1; OVF_WE = 1; OVF_NEXT = 1; step_clr();
    chk("ovf_stalled", 32'(OVERFLOW), 32'h0);

    // PC wrap
    lut_load(5, 'h3FF);
    branch(5);
    chk("wrap_pre", 32'(PC), 32'h3FF);
    step_clr();
    chk("wrap_pc", 32'(PC), 32'h000);

    // Halt wins over branch
    lut_load(6, 'h12);
    branch(6);
    HALT = 1; BRANCH_EN = 1; TARGET_IDX = 4'd3; step_clr();
    chk("halt_done", 32'(DONE), 32'h1);
    chk("halt_pc", 32'(PC), 32'h12);
    chk("halt_taken", 32'(BRANCH_TAKEN), 32'h0);
    step_clr();
    chk("halted_hold_pc", 32'(PC), 32'h12);
    do_start();
    chk("restart_pc", 32'(PC), 32'h0);
    chk("restart_running", 32'(RUNNING), 32'h1);
    chk("restart_cnt", 32'(CYCLE_CNT), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      START      = ($urandom_range(99) < ((m_mode != 1) ? 20 : 2));
      HALT       = ($urandom_range(99) < 3);
      STALL      = ($urandom_range(99) < 20);
      BRANCH_EN  = ($urandom_range(99) < 25);
      TARGET_IDX = IDX_W'($urandom);
      FLAG_WE    = $urandom_range(1); FLAG_NEXT = $urandom_range(1);
      OVF_WE     = $urandom_range(1); OVF_NEXT  = $urandom_range(1);
      LUT_WE     = ($urandom_range(99) < 10);
      LUT_WADDR  = IDX_W'($urandom);
      LUT_WDATA  = PC_W'($urandom);
      step_clr();
    end

    // Counter saturation
    do_start();
    repeat (CNT_MAX) step_clr();
    chk("cnt_full", 32'(CYCLE_CNT), 32'hFFFF);
    repeat (3) step_clr();
    chk("cnt_sat", 32'(CYCLE_CNT), 32'hFFFF);

    // Asynchronous reset mid-run
    do_start();
    lut_load(7, 'h55);
    FLAG_WE = 1; FLAG_NEXT = 1; branch(7);
    chk("mid_pc", 32'(PC), 32'h55);
    chk("mid_flag", 32'(FLAG), 32'h1);
    #2;
    RESET_N = 0;
    model_reset();
    #1;
    chk("async_pc", 32'(PC), 32'h0);
    chk("async_flag", 32'(FLAG), 32'h0);
    chk("async_cnt", 32'(CYCLE_CNT), 32'h0);
    chk("async_running", 32'(RUNNING), 32'h0);
    tick();
    RESET_N = 1;
    tick();
    chk("post_reset_idle", 32'(RUNNING), 32'h0);
    do_start();
    branch(3);
    chk("lut_cleared_pc", 32'(PC), 32'h0);
    chk("lut_cleared_taken", 32'(BRANCH_TAKEN), 32'h1);

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
